// File: rtl/mem_pkg.sv
// Shared memory-bus types used by the core and every MMIO peripheral.
//   mem_access_t         : access size of the current bus cycle
//   mem_exception_mask_t : one-hot exception flags returned by a target
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef logic [1:0] mem_exception_mask_t;

  localparam mem_exception_mask_t MEM_EXCEPTION_NONE               = 2'b00;
  localparam mem_exception_mask_t MEM_EXCEPTION_ADDRESS_MISALIGNED = 2'b01;
  localparam mem_exception_mask_t MEM_EXCEPTION_ACCESS_VIOLATION   = 2'b10;

endpackage

// File: rtl/mmio_console_pkg.sv
// Register map and UART state encoding for the MMIO console transmitter.
// Register indices are word offsets inside the 16-byte window (addr[3:2]).
package mmio_console_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CYCLES  = 2'd2;
  localparam logic [1:0] REG_DROPPED = 2'd3;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // STATUS layout: {24'b0, count[3:0], busy, empty, full}
  function automatic logic [31:0] pack_status(input logic [3:0] count,
                                              input logic       busy,
                                              input logic       empty,
                                              input logic       full);
    return {24'b0, count, busy, empty, full};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word-fall-through read port.
//   clk/rst    : clock, async active-low reset (pointers and count to 0)
//   push/pop   : enqueue push_data / dequeue head; ignored when full/empty
//   pop_data   : current head entry
//   full/empty : occupancy flags; count = entries held (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  assign pop_data = mem_q[rptr_q];
  assign count    = count_q;

endmodule

// File: rtl/mmio_console_tx.sv
// Memory-mapped console transmitter: a 16-byte register window feeding a
// byte FIFO drained by an 8N1 UART.
//   clk, rst          : clock, async active-low reset
//   ena               : state-update enable (reads stay live when low)
//   mem_addr/mem_wr_data/mem_wr_ena/mem_access : core bus request
//   mem_rd_data, mem_exception : combinational response in the access cycle
//   tx                : serial line, idle high
// Registers: 0x0 TXDATA (W), 0x4 STATUS (R), 0x8 CYCLES (R),
//            0xC DROPPED (R, any write clears).
module mmio_console_tx
  import mem_pkg::*;
  import mmio_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wr_data,
  input  logic                mem_wr_ena,
  input  mem_access_t         mem_access,
  output logic [31:0]         mem_rd_data,
  output mem_exception_mask_t mem_exception,
  output logic                tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  // ---------------- state ----------------
  uart_state_t state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [31:0]   dropped_q, dropped_d;

  // ---------------- FIFO ----------------
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          pop_req;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem_wr_data[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Only the low byte of a TXDATA write is transmitted.
  logic unused_wr_hi;
  assign unused_wr_hi = ^mem_wr_data[31:8];

  // ---------------- bus decode ----------------
  logic       hit, misaligned, violation, wr_legal;
  logic [1:0] reg_idx;
  logic [3:0] count4;
  logic       tx_wr, dropped_clr;

  assign count4 = 4'(fifo_count);

  always_comb begin
    hit        = (mem_addr[31:4] == BASE_ADDR[31:4]);
    reg_idx    = mem_addr[3:2];
    misaligned = ((mem_access == MEM_ACCESS_HALF) && mem_addr[0]) ||
                 ((mem_access == MEM_ACCESS_WORD) && (mem_addr[1:0] != 2'b00));
    // TXDATA takes any size; the counters are word-only and STATUS/CYCLES
    // are read-only.
    violation  = (reg_idx != REG_TXDATA) &&
                 ((mem_access != MEM_ACCESS_WORD) ||
                  (mem_wr_ena && ((reg_idx == REG_STATUS) || (reg_idx == REG_CYCLES))));
    mem_exception = MEM_EXCEPTION_NONE;
    mem_rd_data   = '0;
    wr_legal      = 1'b0;
    if (hit) begin
      if (misaligned) begin
        mem_exception = MEM_EXCEPTION_ADDRESS_MISALIGNED;
      end else if (violation) begin
        mem_exception = MEM_EXCEPTION_ACCESS_VIOLATION;
      end else begin
        wr_legal = mem_wr_ena;
        case (reg_idx)
          REG_STATUS:  mem_rd_data = pack_status(count4, busy_q, fifo_empty, fifo_full);
          REG_CYCLES:  mem_rd_data = cycles_q;
          REG_DROPPED: mem_rd_data = dropped_q;
          default:     mem_rd_data = '0;
        endcase
      end
    end
  end

  // full is sampled before this cycle's pop, so a write racing the UART's
  // pop is still dropped.
  always_comb begin
    tx_wr       = wr_legal && (reg_idx == REG_TXDATA);
    dropped_clr = wr_legal && (reg_idx == REG_DROPPED);
    fifo_push   = ena && tx_wr && !fifo_full;
    fifo_pop    = ena && pop_req;
    cycles_d    = cycles_q + 32'd1;
    dropped_d   = dropped_q;
    if (dropped_clr)                                  dropped_d = '0;
    else if (tx_wr && fifo_full && (dropped_q != '1)) dropped_d = dropped_q + 32'd1;
  end

  // ---------------- UART next state ----------------
  logic bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop_req = 1'b0;
    bit_end = (cnt_q == BW'(CLKS_PER_BIT - 1));
    case (state_q)
      UART_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop_req = 1'b1;
          sh_d    = fifo_head;
          state_d = UART_START;
        end
      end
      UART_START: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = UART_DATA;
        end
      end
      UART_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = UART_STOP;
          else                                 bit_d   = bit_q + 3'd1;
        end
      end
      UART_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next frame for back-to-back output.
          if (!fifo_empty) begin
            pop_req = 1'b1;
            sh_d    = fifo_head;
            state_d = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end
      end
    endcase
    // Line and busy are registered from the current state, so both trail
    // the state by one cycle and every bit keeps its full width.
    case (state_q)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = sh_q[0];
      default:    tx_d = 1'b1;
    endcase
    busy_d = (state_q != UART_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= UART_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      cycles_q  <= '0;
      dropped_q <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      cycles_q  <= cycles_d;
      dropped_q <= dropped_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_console_tx.sv
// Bench for mmio_console_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8): directed bus
// sequences with literal expectations, plus a frame-timeline model of the
// serial line that is compared against tx on every falling edge.
module tb_mmio_console_tx;
  import mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_F000;
  localparam int          N     = 4;
  localparam int          DEPTH = 8;
  localparam int          FL    = 10 * N;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                ena = 1'b1;
  logic [31:0]         mem_addr = BASE + 32'h4;
  logic [31:0]         mem_wr_data = '0;
  logic                mem_wr_ena = 1'b0;
  mem_access_t         mem_access = MEM_ACCESS_WORD;
  logic [31:0]         mem_rd_data;
  mem_exception_mask_t mem_exception;
  logic                tx;

  int checks = 0;
  int failures = 0;

  mmio_console_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ena    (mem_wr_ena),
    .mem_access    (mem_access),
    .mem_rd_data   (mem_rd_data),
    .mem_exception (mem_exception),
    .tx            (tx)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Serial line as a timeline: k counts enabled edges since the last pop;
  // the frame occupies k=1..FL, one bit every N edges.
  byte unsigned mq[$];
  logic [31:0]  m_cycles = '0;
  logic [31:0]  m_drop = '0;
  int           m_k = FL + 1;
  logic [7:0]   m_byte = '0;
  logic         m_tx = 1'b1;
  logic         m_busy = 1'b0;
  logic         m_pop, m_full;
  int           m_kn;

  function automatic mem_exception_mask_t exp_exc(input logic [31:0] a, input mem_access_t acc,
                                                  input logic we);
    if (a[31:4] != BASE[31:4]) return MEM_EXCEPTION_NONE;
    if (acc == MEM_ACCESS_HALF && a[0] == 1'b1) return MEM_EXCEPTION_ADDRESS_MISALIGNED;
    if (acc == MEM_ACCESS_WORD && a[1:0] != 2'b00) return MEM_EXCEPTION_ADDRESS_MISALIGNED;
    if (a[3:0] >= 4'h4 && acc != MEM_ACCESS_WORD) return MEM_EXCEPTION_ACCESS_VIOLATION;
    if (we && a[3:0] >= 4'h4 && a[3:0] < 4'hC) return MEM_EXCEPTION_ACCESS_VIOLATION;
    return MEM_EXCEPTION_NONE;
  endfunction

  function automatic logic line_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    n = mq.size();
    return {24'b0, 4'(n), m_busy, (n == 0), (n == DEPTH)};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      m_cycles = '0;
      m_drop   = '0;
      m_k      = FL + 1;
      m_tx     = 1'b1;
      m_busy   = 1'b0;
    end else if (ena) begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (m_k >= FL - 1) && (mq.size() != 0);
      m_cycles = m_cycles + 32'd1;
      m_kn = (m_k < FL + 1) ? m_k + 1 : FL + 1;
      if (m_kn >= 1 && m_kn <= FL) begin
        m_tx   = line_bit(m_byte, (m_kn - 1) / N);
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
      m_k = m_kn;
      if (m_pop) begin
        m_byte = mq.pop_front();
        m_k    = 0;
      end
      if (mem_wr_ena && mem_addr[31:4] == BASE[31:4] &&
          exp_exc(mem_addr, mem_access, 1'b1) == MEM_EXCEPTION_NONE) begin
        if (mem_addr[3:2] == 2'd0) begin
          if (m_full) begin
            if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
          end else begin
            mq.push_back(mem_wr_data[7:0]);
          end
        end else if (mem_addr[3:2] == 2'd3) begin
          m_drop = '0;
        end
      end
    end
  end

  // Line compare, every falling edge.
  initial forever begin
    @(negedge clk);
    chk("tx_vs_model", 32'(tx), 32'(m_tx));
  end

  // ---------------- bus helpers ----------------
  task automatic set_bus(input logic [31:0] a, input mem_access_t acc, input logic we,
                         input logic [31:0] d);
    mem_addr    = a;
    mem_access  = acc;
    mem_wr_ena  = we;
    mem_wr_data = d;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    set_bus(a, MEM_ACCESS_WORD, 1'b0, 32'h0);
    #1;
    chk(nm, mem_rd_data, exp);
    chk({nm, "_exc"}, 32'(mem_exception), 32'(MEM_EXCEPTION_NONE));
  endtask

  task automatic wr(input logic [31:0] a, input mem_access_t acc, input logic [31:0] d);
    set_bus(a, acc, 1'b1, d);
    @(negedge clk);
    set_bus(BASE + 32'h4, MEM_ACCESS_WORD, 1'b0, 32'h0);
  endtask

  // Misuse table: address, size, write, expected flag.
  logic [31:0] ex_addr [9] = '{32'hF002, 32'hF004, 32'hF001, 32'hF008, 32'hF00C,
                               32'hF008, 32'hF002, 32'hF00D, 32'hF003};
  mem_access_t ex_acc  [9] = '{MEM_ACCESS_WORD, MEM_ACCESS_WORD, MEM_ACCESS_HALF,
                               MEM_ACCESS_BYTE, MEM_ACCESS_HALF, MEM_ACCESS_WORD,
                               MEM_ACCESS_HALF, MEM_ACCESS_BYTE, MEM_ACCESS_WORD};
  logic        ex_we   [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0]  ex_exp  [9] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01};

  logic [9:0] a5_frame = 10'b11_0100_1010;  // start, A5 LSB first, stop

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'h1);
    rd_chk("rst_status", BASE + 32'h4, 32'h0000_0002);
    rd_chk("rst_cycles", BASE + 32'h8, 32'h0);
    rd_chk("rst_dropped", BASE + 32'hC, 32'h0);

    // ---- CYCLES: 100 enabled edges, then 100 edges with 10 frozen ----
    rst = 1'b1;
    for (int i = 0; i < 100; i++) @(negedge clk);
    rd_chk("cycles_100", BASE + 32'h8, 32'd100);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ena = (i >= 20 && i < 30) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    ena = 1'b1;
    rd_chk("cycles_90", BASE + 32'h8, 32'd90);
    rd_chk("cycles_model", BASE + 32'h8, m_cycles);

    // ---- single frame 0xA5 ----
    wr(BASE, MEM_ACCESS_WORD, 32'h0000_00A5);
    chk("lat_tx_e0", 32'(tx), 32'h1);
    rd_chk("lat_status_e0", BASE + 32'h4, 32'h0000_0008);
    @(negedge clk);
    chk("lat_tx_e1", 32'(tx), 32'h1);
    rd_chk("lat_status_e1", BASE + 32'h4, 32'h0000_0002);
    for (int j = 0; j < FL; j++) begin
      @(negedge clk);
      #1;
      chk("a5_tx", 32'(tx), 32'(a5_frame[j/N]));
      chk("a5_busy", 32'(mem_rd_data[2]), 32'h1);
    end
    @(negedge clk);
    chk("a5_after_tx", 32'(tx), 32'h1);
    rd_chk("a5_after_status", BASE + 32'h4, 32'h0000_0002);

    // ---- misaligned / violation, no side effects ----
    for (int i = 0; i < 9; i++) begin
      set_bus(ex_addr[i], ex_acc[i], ex_we[i], 32'h0000_0077);
      #1;
      chk("exc_flag", 32'(mem_exception), 32'(ex_exp[i]));
      chk("exc_flag_model", 32'(mem_exception), 32'(exp_exc(ex_addr[i], ex_acc[i], ex_we[i])));
      chk("exc_rdata", mem_rd_data, 32'h0);
      @(negedge clk);
    end
    rd_chk("exc_status", BASE + 32'h4, 32'h0000_0002);

    // ---- address miss ----
    set_bus(32'h0000_E000, MEM_ACCESS_WORD, 1'b1, 32'h0000_0041);
    #1;
    chk("miss_rdata", mem_rd_data, 32'h0);
    chk("miss_exc", 32'(mem_exception), 32'(MEM_EXCEPTION_NONE));
    @(negedge clk);
    rd_chk("miss_read", 32'h0000_E004, 32'h0);
    rd_chk("miss_status", BASE + 32'h4, 32'h0000_0002);

    // ---- overflow while the UART is mid-frame ----
    wr(BASE, MEM_ACCESS_BYTE, 32'h0000_0011);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      ena = 1'b1;
      set_bus(BASE, MEM_ACCESS_BYTE, 1'b1, 32'h20 + 32'(i));
      @(negedge clk);
      set_bus(BASE + 32'h4, MEM_ACCESS_WORD, 1'b0, 32'h0);
      ena = 1'b0;
      @(negedge clk);
    end
    ena = 1'b1;
    rd_chk("full_status", BASE + 32'h4, 32'h0000_0045);
    rd_chk("full_status_model", BASE + 32'h4, m_status());
    rd_chk("full_dropped", BASE + 32'hC, 32'd2);
    // Keep writing across a pop edge: the write on the pop edge is dropped.
    for (int i = 0; i < 60; i++) begin
      set_bus(BASE, MEM_ACCESS_BYTE, 1'b1, 32'h80 + 32'(i));
      @(negedge clk);
    end
    rd_chk("race_dropped", BASE + 32'hC, 32'd61);
    rd_chk("race_dropped_model", BASE + 32'hC, m_drop);
    rd_chk("race_status", BASE + 32'h4, 32'h0000_0045);
    wr(BASE + 32'hC, MEM_ACCESS_WORD, 32'hDEAD_BEEF);
    rd_chk("clr_dropped", BASE + 32'hC, 32'h0);
    for (int i = 0; i < 400; i++) @(negedge clk);
    rd_chk("drain_status", BASE + 32'h4, 32'h0000_0002);
    rd_chk("drain_cycles_model", BASE + 32'h8, m_cycles);

    // ---- reset mid-DATA ----
    wr(BASE, MEM_ACCESS_WORD, 32'h0000_0000);
    repeat (12) @(negedge clk);
    chk("mid_data_tx", 32'(tx), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd_chk("post_rst_status", BASE + 32'h4, 32'h0000_0002);
    chk("post_rst_tx", 32'(tx), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
